// File: rtl/alu_seq.sv
// alu_seq: four-state sequencer feeding an external 8-bit ALU from a
// 4-entry register file, writing results back and maintaining carry/zero.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN (zero flag register present
// when defined; o_zero tied low otherwise).
module alu_seq #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_instr_valid,
   output logic              o_instr_ready,
   input  logic [7:0]        i_instr,
   input  logic              i_ld_en,
   input  logic [1:0]        i_ld_addr,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic [1:0]        i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic [DATA_W-1:0] o_alu_a,
   output logic [DATA_W-1:0] o_alu_b,
   output logic              o_alu_cin,
   output logic [2:0]        o_alu_op,
   input  logic [DATA_W-1:0] i_alu_y,
   input  logic              i_alu_cout,
   output logic              o_carry,
   output logic              o_zero,
   output logic              o_done,
   output logic              o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_rf [4];
   logic [7:0]        r_instr;
   logic [DATA_W-1:0] r_alu_a, r_alu_b;
   logic              r_alu_cin;
   logic [2:0]        r_alu_op;
   logic              r_carry;

   logic [2:0]        w_op;
   logic [1:0]        w_dst, w_src;
   logic              w_cin_sel;
   logic              w_accept;
   logic              w_carry_op;

   assign w_op      = r_instr[7:5];
   assign w_dst     = r_instr[4:3];
   assign w_src     = r_instr[2:1];
   assign w_cin_sel = r_instr[0];
   assign w_accept  = i_instr_valid & o_instr_ready;
   // Only the shift/arithmetic ops (RRC, RLC, ADD, SUB) produce a meaningful carry.
   assign w_carry_op = (r_alu_op == 3'b011) || (r_alu_op == 3'b100) ||
                       (r_alu_op == 3'b101) || (r_alu_op == 3'b110);

   assign o_rd_data = r_rf[i_rd_addr];
   assign o_alu_a   = r_alu_a;
   assign o_alu_b   = r_alu_b;
   assign o_alu_cin = r_alu_cin;
   assign o_alu_op  = r_alu_op;
   assign o_carry   = r_carry;

   // State register; reset aborts any in-flight instruction.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and handshake/status outputs; a load in IDLE blocks acceptance.
   always_comb begin
      w_next        = r_state;
      o_instr_ready = 1'b0;
      o_done        = 1'b0;
      o_busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            o_busy        = 1'b0;
            o_instr_ready = !i_ld_en;
            if (i_instr_valid && !i_ld_en) w_next = S_READ;
         end
         S_READ: w_next = S_EXEC;
         S_EXEC: w_next = S_DONE;
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: loads and instruction latch in IDLE, operand fetch in READ,
   // write-back and carry update at the close of EXEC.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 4; i++) r_rf[i] <= '0;
         r_instr   <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_cin <= 1'b0;
         r_alu_op  <= '0;
         r_carry   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_ld_en)       r_rf[i_ld_addr] <= i_ld_data;
               else if (w_accept) r_instr         <= i_instr;
            end
            S_READ: begin
               r_alu_a   <= r_rf[w_dst];
               r_alu_b   <= r_rf[w_src];
               r_alu_op  <= w_op;
               r_alu_cin <= w_cin_sel & r_carry;
            end
            S_EXEC: begin
               r_rf[w_dst] <= i_alu_y;
               if (w_carry_op) r_carry <= i_alu_cout;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic r_zero;
   // Zero flag follows every committed result, regardless of opcode.
   always_ff @(posedge i_clk) begin
      if (i_rst)                  r_zero <= 1'b0;
      else if (r_state == S_EXEC) r_zero <= (i_alu_y == '0);
   end
   assign o_zero = r_zero;
`else
   assign o_zero = 1'b0;
`endif

endmodule
